// File: rtl/stopwatch_core.sv
// stopwatch_core: BCD MM:SS stopwatch with run/pause, clear and manual adjust.
//
// Ports:
//   i_clk        system clock, sole clock
//   i_rst        synchronous reset, active-low (0 = reset)
//   i_pause_btn  debounced pause level; each rising level toggles RUN/PAUSED
//   i_reset_btn  debounced clear level; each rising level clears the time to 00:00
//   i_sel        adjust field select: 0 = minutes, 1 = seconds
//   i_adj        1 = adjust mode (normal counting frozen, selected field steps)
//   o_min_tens   minutes tens digit, BCD 0-5
//   o_min_ones   minutes ones digit, BCD 0-9
//   o_sec_tens   seconds tens digit, BCD 0-5
//   o_sec_ones   seconds ones digit, BCD 0-9
//   o_running    1 = RUN, 0 = PAUSED
//   o_adj_blink  1 outside adjust mode; toggles on every adjust step in adjust mode
module stopwatch_core #(
  parameter int unsigned ONE_HZ_DIV = 100_000_000,
  parameter int unsigned ADJ_DIV    = 50_000_000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_pause_btn,
  input  logic       i_reset_btn,
  input  logic       i_sel,
  input  logic       i_adj,
  output logic [3:0] o_min_tens,
  output logic [3:0] o_min_ones,
  output logic [3:0] o_sec_tens,
  output logic [3:0] o_sec_ones,
  output logic       o_running,
  output logic       o_adj_blink
);

  localparam int unsigned DivW = (ONE_HZ_DIV > 1) ? $clog2(ONE_HZ_DIV) : 1;
  localparam int unsigned AdjW = (ADJ_DIV > 1) ? $clog2(ADJ_DIV) : 1;
  localparam logic [DivW-1:0] DivMax = DivW'(ONE_HZ_DIV - 1);
  localparam logic [AdjW-1:0] AdjMax = AdjW'(ADJ_DIV - 1);

  typedef enum logic [0:0] {StRun, StPaused} state_e;

  state_e          r_state;
  state_e          w_state_d;
  logic            r_pause_q;
  logic            r_reset_q;
  logic [DivW-1:0] r_div_1hz;
  logic [DivW-1:0] w_div_1hz_d;
  logic [AdjW-1:0] r_div_adj;
  logic [AdjW-1:0] w_div_adj_d;
  logic [7:0]      r_min;   // {tens, ones}
  logic [7:0]      r_sec;   // {tens, ones}
  logic [7:0]      w_min_d;
  logic [7:0]      w_sec_d;
  logic            r_blink;
  logic            w_blink_d;
  logic            w_pause_evt;
  logic            w_reset_evt;
  logic            w_tick;
  logic            w_step;

  // Two-digit BCD increment modulo 60; caller decides whether a wrap carries.
  function automatic logic [7:0] inc60(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'd9) begin
      if (v[7:4] == 4'd5) r = 8'h00;
      else                r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  assign w_pause_evt = i_pause_btn & ~r_pause_q;
  assign w_reset_evt = i_reset_btn & ~r_reset_q;

  // FSM next state: pause toggles even in adjust mode; it takes effect once adj drops.
  always_comb begin
    w_state_d = r_state;
    if (w_pause_evt) begin
      w_state_d = (r_state == StRun) ? StPaused : StRun;
    end
  end

  // Dividers, adjust blink and time digits.
  always_comb begin
    w_div_1hz_d = r_div_1hz;
    w_div_adj_d = '0;
    w_tick      = 1'b0;
    w_step      = 1'b0;
    w_blink_d   = 1'b1;
    w_min_d     = r_min;
    w_sec_d     = r_sec;

    if (!i_adj && (r_state == StRun)) begin
      if (r_div_1hz == DivMax) begin
        w_div_1hz_d = '0;
        w_tick      = 1'b1;
      end else begin
        w_div_1hz_d = r_div_1hz + DivW'(1);
      end
    end

    if (i_adj) begin
      w_blink_d = r_blink;
      if (r_div_adj == AdjMax) begin
        w_div_adj_d = '0;
        w_step      = 1'b1;
        w_blink_d   = ~r_blink;
      end else begin
        w_div_adj_d = r_div_adj + AdjW'(1);
      end
    end

    // Clear has priority over any simultaneous tick or adjust step.
    if (w_reset_evt) begin
      w_min_d     = 8'h00;
      w_sec_d     = 8'h00;
      w_div_1hz_d = '0;
    end else if (w_tick) begin
      w_sec_d = inc60(r_sec);
      if (r_sec == 8'h59) w_min_d = inc60(r_min);
    end else if (w_step) begin
      if (i_sel) w_sec_d = inc60(r_sec);
      else       w_min_d = inc60(r_min);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state   <= StRun;
      // Load current levels so a button held through reset makes no event on release.
      r_pause_q <= i_pause_btn;
      r_reset_q <= i_reset_btn;
      r_div_1hz <= '0;
      r_div_adj <= '0;
      r_min     <= 8'h00;
      r_sec     <= 8'h00;
      r_blink   <= 1'b1;
    end else begin
      r_state   <= w_state_d;
      r_pause_q <= i_pause_btn;
      r_reset_q <= i_reset_btn;
      r_div_1hz <= w_div_1hz_d;
      r_div_adj <= w_div_adj_d;
      r_min     <= w_min_d;
      r_sec     <= w_sec_d;
      r_blink   <= w_blink_d;
    end
  end

  assign o_min_tens  = r_min[7:4];
  assign o_min_ones  = r_min[3:0];
  assign o_sec_tens  = r_sec[7:4];
  assign o_sec_ones  = r_sec[3:0];
  assign o_running   = (r_state == StRun);
  assign o_adj_blink = r_blink;

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed bench for stopwatch_core with ONE_HZ_DIV=10, ADJ_DIV=4.
module tb_stopwatch_core;

  logic       clk;
  logic       rst;
  logic       pause_btn;
  logic       reset_btn;
  logic       sel;
  logic       adj;
  logic [3:0] min_tens;
  logic [3:0] min_ones;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic       running;
  logic       adj_blink;

  int n_checks;
  int n_fail;

  stopwatch_core #(
    .ONE_HZ_DIV (10),
    .ADJ_DIV    (4)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_pause_btn (pause_btn),
    .i_reset_btn (reset_btn),
    .i_sel       (sel),
    .i_adj       (adj),
    .o_min_tens  (min_tens),
    .o_min_ones  (min_ones),
    .o_sec_tens  (sec_tens),
    .o_sec_ones  (sec_ones),
    .o_running   (running),
    .o_adj_blink (adj_blink)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges, then park on the following falling edge.
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    cycles(2);
    rst = 1'b1;
  endtask

  function automatic logic [15:0] now();
    return {min_tens, min_ones, sec_tens, sec_ones};
  endfunction

  task automatic test_reset();
    pause_btn = 1'b0; reset_btn = 1'b0; sel = 1'b0; adj = 1'b0; rst = 1'b0;
    cycles(2);
    n_checks++;
    if (now() !== 16'h0000) begin
      n_fail++; $display("FAIL reset_time got %h expected 0000", now());
    end
    n_checks++;
    if (running !== 1'b1 || adj_blink !== 1'b1) begin
      n_fail++; $display("FAIL reset_flags got run=%b blink=%b expected 1 1", running, adj_blink);
    end
    rst = 1'b1;
  endtask

  task automatic test_count_wrap();
    do_reset();
    cycles(35990);
    n_checks++;
    if (now() !== 16'h5959) begin
      n_fail++; $display("FAIL count_5959 got %h expected 5959", now());
    end
    cycles(9);
    n_checks++;
    if (now() !== 16'h5959) begin
      n_fail++; $display("FAIL before_wrap got %h expected 5959", now());
    end
    cycles(1);
    n_checks++;
    if (now() !== 16'h0000 || running !== 1'b1) begin
      n_fail++; $display("FAIL wrap got %h run=%b expected 0000 run=1", now(), running);
    end
  endtask

  task automatic test_pause();
    do_reset();
    cycles(32);            // 00:03 with divider at 2
    pause_btn = 1'b1;
    cycles(1);             // pause edge, divider advances to 3
    n_checks++;
    if (running !== 1'b0) begin
      n_fail++; $display("FAIL pause_enter got run=%b expected 0", running);
    end
    cycles(49);
    n_checks++;
    if (running !== 1'b0) begin
      n_fail++; $display("FAIL pause_held got run=%b expected 0", running);
    end
    pause_btn = 1'b0;
    cycles(100);
    n_checks++;
    if (now() !== 16'h0003 || running !== 1'b0) begin
      n_fail++; $display("FAIL pause_frozen got %h run=%b expected 0003 run=0", now(), running);
    end
    pause_btn = 1'b1;
    cycles(1);             // resume edge, divider held at 3
    pause_btn = 1'b0;
    n_checks++;
    if (running !== 1'b1) begin
      n_fail++; $display("FAIL resume got run=%b expected 1", running);
    end
    cycles(6);
    n_checks++;
    if (now() !== 16'h0003) begin
      n_fail++; $display("FAIL resume_early got %h expected 0003", now());
    end
    cycles(1);
    n_checks++;
    if (now() !== 16'h0004) begin
      n_fail++; $display("FAIL resume_tick got %h expected 0004", now());
    end
  endtask

  task automatic test_clear();
    do_reset();
    cycles(70);
    reset_btn = 1'b1;
    cycles(1);
    n_checks++;
    if (now() !== 16'h0000 || running !== 1'b1) begin
      n_fail++; $display("FAIL clear_run got %h run=%b expected 0000 run=1", now(), running);
    end
    cycles(5);             // level still held: no further clear
    reset_btn = 1'b0;
    n_checks++;
    if (now() !== 16'h0000) begin
      n_fail++; $display("FAIL clear_hold got %h expected 0000", now());
    end
    cycles(29);            // clear edge zeroed divider: 35 edges total -> 00:03
    pause_btn = 1'b1;
    cycles(1);
    pause_btn = 1'b0;
    n_checks++;
    if (now() !== 16'h0003 || running !== 1'b0) begin
      n_fail++; $display("FAIL clear_prep got %h run=%b expected 0003 run=0", now(), running);
    end
    reset_btn = 1'b1;
    cycles(1);
    reset_btn = 1'b0;
    n_checks++;
    if (now() !== 16'h0000 || running !== 1'b0) begin
      n_fail++; $display("FAIL clear_paused got %h run=%b expected 0000 run=0", now(), running);
    end
    cycles(1);
    pause_btn = 1'b1; reset_btn = 1'b1;
    cycles(1);
    pause_btn = 1'b0; reset_btn = 1'b0;
    n_checks++;
    if (now() !== 16'h0000 || running !== 1'b1) begin
      n_fail++; $display("FAIL clear_and_pause got %h run=%b expected 0000 run=1", now(), running);
    end
  endtask

  task automatic test_adjust();
    do_reset();
    cycles(50);
    adj = 1'b1; sel = 1'b0;
    cycles(3);
    n_checks++;
    if (now() !== 16'h0005 || adj_blink !== 1'b1) begin
      n_fail++; $display("FAIL adj_wait got %h blink=%b expected 0005 blink=1", now(), adj_blink);
    end
    cycles(1);
    n_checks++;
    if (now() !== 16'h0105 || adj_blink !== 1'b0) begin
      n_fail++; $display("FAIL adj_step1 got %h blink=%b expected 0105 blink=0", now(), adj_blink);
    end
    cycles(4);
    n_checks++;
    if (now() !== 16'h0205 || adj_blink !== 1'b1) begin
      n_fail++; $display("FAIL adj_step2 got %h blink=%b expected 0205 blink=1", now(), adj_blink);
    end
    sel = 1'b1;
    cycles(4 * 53);
    n_checks++;
    if (now() !== 16'h0258) begin
      n_fail++; $display("FAIL adj_sec58 got %h expected 0258", now());
    end
    cycles(4);
    n_checks++;
    if (now() !== 16'h0259) begin
      n_fail++; $display("FAIL adj_sec59 got %h expected 0259", now());
    end
    cycles(4);
    n_checks++;
    if (now() !== 16'h0200 || adj_blink !== 1'b0) begin
      n_fail++; $display("FAIL adj_sec_wrap got %h blink=%b expected 0200 blink=0", now(), adj_blink);
    end
    adj = 1'b0;
    cycles(1);
    n_checks++;
    if (adj_blink !== 1'b1 || now() !== 16'h0200) begin
      n_fail++; $display("FAIL adj_exit got %h blink=%b expected 0200 blink=1", now(), adj_blink);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    cycles(9);             // divider at 9: next edge is a tick
    reset_btn = 1'b1;
    cycles(1);
    reset_btn = 1'b0;
    n_checks++;
    if (now() !== 16'h0000) begin
      n_fail++; $display("FAIL clear_vs_tick got %h expected 0000", now());
    end
    cycles(9);
    n_checks++;
    if (now() !== 16'h0000) begin
      n_fail++; $display("FAIL clear_div_early got %h expected 0000", now());
    end
    cycles(1);
    n_checks++;
    if (now() !== 16'h0001) begin
      n_fail++; $display("FAIL clear_div_tick got %h expected 0001", now());
    end
    cycles(25);
    pause_btn = 1'b1; rst = 1'b0;
    cycles(2);
    rst = 1'b1;
    cycles(3);
    pause_btn = 1'b0;
    n_checks++;
    if (now() !== 16'h0000 || running !== 1'b1) begin
      n_fail++; $display("FAIL rst_held_pause got %h run=%b expected 0000 run=1", now(), running);
    end
    cycles(7);             // 10 edges after rst release
    n_checks++;
    if (now() !== 16'h0001 || running !== 1'b1) begin
      n_fail++; $display("FAIL rst_restart got %h run=%b expected 0001 run=1", now(), running);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_count_wrap();
    test_pause();
    test_clear();
    test_adjust();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
